reg_writeback_unit: RTL and testbench
=====================================

Name: reg_writeback_unit

Overview:
- Writeback stage that produces the write side of the integer register file (write enable, address, data, valid pulse) from retiring instructions.
- Accepts one result per handshake from execute. Non-loads commit directly; loads wait for the LSU read response, then sign/zero-extend and align the data.
- Sits between EXU/LSU and the register file.
- Exposes pending-destination info for hazard detection in decode.

Parameters:
- ADDR_WIDTH, 5, register index width.
- DATA_WIDTH, 32, register/result/load data width; fixed at 32 for the load-extension logic.

Ports:
- i_clock  input  1  clock, all state on rising edge.
- i_reset_n  input  1  reset, asynchronous assert, active-low.
- i_valid  input  1  EXU result valid.
- o_ready  output  1  unit can accept a result.
- i_rd  input  ADDR_WIDTH  destination register.
- i_rd_wen  input  1  instruction writes rd.
- i_result  input  DATA_WIDTH  ALU/CSR result, or load address for loads.
- i_is_load  input  1  result must come from the LSU.
- i_load_funct3  input  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- i_rvalid  input  1  LSU read data valid.
- i_rdata  input  DATA_WIDTH  raw aligned word from the LSU.
- o_rready  output  1  unit accepts LSU data.
- o_wen  output  1  register write enable.
- o_waddr  output  ADDR_WIDTH  register write address.
- o_wdata  output  DATA_WIDTH  register write data.
- o_valid  output  1  one-cycle commit pulse; drives the register file valid input.
- o_busy  output  1  an instruction is pending in this stage.
- o_busy_rd  output  ADDR_WIDTH  pending rd; 0 when not busy or no write.

Behaviour:
- States: IDLE, LOAD_WAIT, COMMIT. Reset state is IDLE.
- Reset values: all outputs 0 except o_ready=1. All latched fields are cleared.
- o_ready is 1 only in IDLE. o_rready is 1 only in LOAD_WAIT.
- IDLE with i_valid=1 (handshake):
  - Latch rd, rd_wen, result, funct3, and offset = i_result[1:0].
  - Next state is LOAD_WAIT if i_is_load=1, else COMMIT.
- LOAD_WAIT:
  - Hold until i_rvalid=1, then latch the extended data and go to COMMIT.
  - i_rvalid in any other state is ignored.
- Load extension:
  - lb/lbu: byte selected by offset (0 gives [7:0], 3 gives [31:24]); sign- or zero-extended.
  - lh/lhu: offset[1] selects the half ([15:0] or [31:16]); offset[0] is ignored; sign- or zero-extended.
  - lw and any undefined funct3: full word.
- COMMIT:
  - o_valid=1 for exactly one cycle; o_waddr and o_wdata come from latched values.
  - o_wen = latched rd_wen && rd!=0.
  - Next state is IDLE.
- Outputs are registered; o_wen, o_waddr and o_wdata are valid only while o_valid=1 and are 0 otherwise.
- Latency:
  - Non-load accepted at edge N gives o_valid high in cycle N+1.
  - Load with i_rvalid sampled at edge M gives o_valid in cycle M+1.
  - Accept-to-accept throughput is 2 cycles for non-loads.
- No combinational path from i_valid to o_ready. A new i_valid during COMMIT waits until IDLE.
- Hazard outputs:
  - o_busy = state!=IDLE.
  - o_busy_rd = latched rd when busy && rd_wen, else 0.
- Reset asserted mid-operation: immediate return to IDLE. The pending write is dropped and o_valid is never raised. A later i_rvalid is ignored.

Optional Feature:
- Macro WB_COMMIT_TRACE_EN.
- Defined:
  - Adds input i_pc (32 bit), latched at the handshake.
  - Adds output o_commit_pc (32 bit), valid with o_valid.
  - Adds output o_retired (64 bit), a counter incremented on every o_valid pulse, reset 0, wraps at 2^64.
- Undefined: these ports and registers do not exist. Core behaviour is identical.

Test Plan:
- Reset, then idle → o_ready=1, o_valid=0, o_busy=0, o_busy_rd=0.
- Non-load rd=5, result=0x1234_5678, wen=1, accepted at edge N → cycle N+1: o_valid=1, o_wen=1, o_waddr=5, o_wdata=0x12345678; cycle N+2: o_ready=1.
- Load lb, addr=...03, i_rdata=0x80FF_0000 after 3 wait cycles → o_busy_rd=rd throughout; o_wdata=0xFFFF_FF80.
- Load lhu, addr=...02, i_rdata=0x8001_1234 → o_wdata=0x0000_8001.
- Load lw, addr=...00, i_rdata=0xDEAD_BEEF → o_wdata=0xDEADBEEF.
- Non-load with rd=0, wen=1 → o_valid=1, o_wen=0.
- Reset pulsed during LOAD_WAIT, then i_rvalid=1 → no o_valid, state IDLE.
- Trace enabled, i_pc=0x8000_0004, 3 commits → o_retired=3; o_commit_pc matches each pulse.

Source files
------------

// File: rtl/reg_writeback_unit.sv
// Integer register-file writeback stage: commits ALU/CSR results directly, waits on LSU data for loads.
// Optional commit trace (i_pc / o_commit_pc / o_retired) is enabled with WB_COMMIT_TRACE_EN.
module reg_writeback_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_rd,
  input  logic                  i_rd_wen,
  input  logic [DATA_WIDTH-1:0] i_result,
  input  logic                  i_is_load,
  input  logic [2:0]            i_load_funct3,
  input  logic                  i_rvalid,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_rready,
  output logic                  o_wen,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] o_busy_rd
`ifdef WB_COMMIT_TRACE_EN
  ,
  input  logic [31:0]           i_pc,
  output logic [31:0]           o_commit_pc,
  output logic [63:0]           o_retired
`endif
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_WAIT = 2'd1,
    S_COMMIT    = 2'd2
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Byte/half selection assumes a 32-bit word; lw and undefined funct3 pass the word through.
  function automatic logic [DATA_WIDTH-1:0] extend_load(
    input logic [DATA_WIDTH-1:0] raw,
    input logic [2:0]            funct3,
    input logic [1:0]            offset
  );
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    case (offset)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    half_sel = offset[1] ? raw[31:16] : raw[15:0];
    case (funct3)
      F3_LB:   extend_load = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_LH:   extend_load = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F3_LBU:  extend_load = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_LHU:  extend_load = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: extend_load = raw;
    endcase
  endfunction

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rd_q, rd_d;
  logic                    rd_wen_q, rd_wen_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [1:0]              offset_q, offset_d;

  logic                    ready_q, ready_d;
  logic                    rready_q, rready_d;
  logic                    valid_q, valid_d;
  logic                    wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    busy_q, busy_d;
  logic [ADDR_WIDTH-1:0]   busy_rd_q, busy_rd_d;

  logic                    accept;
  logic                    load_rsp;
  logic                    commit_next;

`ifdef WB_COMMIT_TRACE_EN
  logic [31:0]             pc_q, pc_d;
  logic [31:0]             commit_pc_q, commit_pc_d;
  logic [63:0]             retired_q, retired_d;
`endif

  assign accept   = (state_q == S_IDLE) && i_valid;
  assign load_rsp = (state_q == S_LOAD_WAIT) && i_rvalid;

  // State register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (i_valid) state_d = i_is_load ? S_LOAD_WAIT : S_COMMIT;
      S_LOAD_WAIT: if (i_rvalid) state_d = S_COMMIT;
      S_COMMIT:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Latched instruction fields; load data overwrites the address once the LSU responds
  always_comb begin
    rd_d     = rd_q;
    rd_wen_d = rd_wen_q;
    data_d   = data_q;
    funct3_d = funct3_q;
    offset_d = offset_q;
`ifdef WB_COMMIT_TRACE_EN
    pc_d     = pc_q;
`endif
    if (accept) begin
      rd_d     = i_rd;
      rd_wen_d = i_rd_wen;
      data_d   = i_result;
      funct3_d = i_load_funct3;
      offset_d = i_result[1:0];
`ifdef WB_COMMIT_TRACE_EN
      pc_d     = i_pc;
`endif
    end else if (load_rsp) begin
      data_d = extend_load(i_rdata, funct3_q, offset_q);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_q     <= '0;
      rd_wen_q <= 1'b0;
      data_q   <= '0;
      funct3_q <= '0;
      offset_q <= '0;
    end else begin
      rd_q     <= rd_d;
      rd_wen_q <= rd_wen_d;
      data_q   <= data_d;
      funct3_q <= funct3_d;
      offset_q <= offset_d;
    end
  end

  // Output logic: computed from the next state so every output is a flop
  always_comb begin
    commit_next = (state_d == S_COMMIT);
    ready_d     = (state_d == S_IDLE);
    rready_d    = (state_d == S_LOAD_WAIT);
    valid_d     = commit_next;
    wen_d       = commit_next && rd_wen_d && (rd_d != '0);
    waddr_d     = commit_next ? rd_d : '0;
    wdata_d     = commit_next ? data_d : '0;
    busy_d      = (state_d != S_IDLE);
    busy_rd_d   = (busy_d && rd_wen_d) ? rd_d : '0;
`ifdef WB_COMMIT_TRACE_EN
    commit_pc_d = commit_next ? pc_d : '0;
    retired_d   = retired_q + 64'(commit_next);
`endif
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ready_q   <= 1'b1;
      rready_q  <= 1'b0;
      valid_q   <= 1'b0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      busy_rd_q <= '0;
    end else begin
      ready_q   <= ready_d;
      rready_q  <= rready_d;
      valid_q   <= valid_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      busy_rd_q <= busy_rd_d;
    end
  end

`ifdef WB_COMMIT_TRACE_EN
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pc_q        <= '0;
      commit_pc_q <= '0;
      retired_q   <= '0;
    end else begin
      pc_q        <= pc_d;
      commit_pc_q <= commit_pc_d;
      retired_q   <= retired_d;
    end
  end

  assign o_commit_pc = commit_pc_q;
  assign o_retired   = retired_q;
`endif

  assign o_ready   = ready_q;
  assign o_rready  = rready_q;
  assign o_valid   = valid_q;
  assign o_wen     = wen_q;
  assign o_waddr   = waddr_q;
  assign o_wdata   = wdata_q;
  assign o_busy    = busy_q;
  assign o_busy_rd = busy_rd_q;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit: commit timing, load extension, hazard outputs, reset abort.
module tb_reg_writeback_unit;

  logic        i_clock = 1'b0;
  logic        i_reset_n;
  logic        i_valid;
  logic        o_ready;
  logic [4:0]  i_rd;
  logic        i_rd_wen;
  logic [31:0] i_result;
  logic        i_is_load;
  logic [2:0]  i_load_funct3;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        o_rready;
  logic        o_wen;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata;
  logic        o_valid;
  logic        o_busy;
  logic [4:0]  o_busy_rd;
`ifdef WB_COMMIT_TRACE_EN
  logic [31:0] i_pc;
  logic [31:0] o_commit_pc;
  logic [63:0] o_retired;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clock = ~i_clock;

  reg_writeback_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .i_clock       (i_clock),
    .i_reset_n     (i_reset_n),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_rd          (i_rd),
    .i_rd_wen      (i_rd_wen),
    .i_result      (i_result),
    .i_is_load     (i_is_load),
    .i_load_funct3 (i_load_funct3),
    .i_rvalid      (i_rvalid),
    .i_rdata       (i_rdata),
    .o_rready      (o_rready),
    .o_wen         (o_wen),
    .o_waddr       (o_waddr),
    .o_wdata       (o_wdata),
    .o_valid       (o_valid),
    .o_busy        (o_busy),
    .o_busy_rd     (o_busy_rd)
`ifdef WB_COMMIT_TRACE_EN
    ,
    .i_pc          (i_pc),
    .o_commit_pc   (o_commit_pc),
    .o_retired     (o_retired)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic drive_op(input logic [4:0] rd, input logic wen, input logic [31:0] res,
                          input logic is_load, input logic [2:0] f3);
    i_valid       = 1'b1;
    i_rd          = rd;
    i_rd_wen      = wen;
    i_result      = res;
    i_is_load     = is_load;
    i_load_funct3 = f3;
  endtask

  task automatic clear_op();
    i_valid   = 1'b0;
    i_is_load = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input int waits, input logic [31:0] exp);
    drive_op(rd, 1'b1, addr, 1'b1, f3);
    tick();
    clear_op();
    chk({tag, ".rready"}, 64'(o_rready), 64'd1);
    chk({tag, ".ready_low"}, 64'(o_ready), 64'd0);
    chk({tag, ".busy_rd"}, 64'(o_busy_rd), 64'(rd));
    for (int i = 0; i < waits; i++) begin
      tick();
      chk({tag, ".wait_busy_rd"}, 64'(o_busy_rd), 64'(rd));
      chk({tag, ".wait_no_valid"}, 64'(o_valid), 64'd0);
    end
    i_rvalid = 1'b1;
    i_rdata  = rdata;
    tick();
    i_rvalid = 1'b0;
    i_rdata  = 32'h0;
    chk({tag, ".valid"}, 64'(o_valid), 64'd1);
    chk({tag, ".wen"}, 64'(o_wen), 64'd1);
    chk({tag, ".waddr"}, 64'(o_waddr), 64'(rd));
    chk({tag, ".wdata"}, 64'(o_wdata), 64'(exp));
    chk({tag, ".rready_low"}, 64'(o_rready), 64'd0);
    tick();
    chk({tag, ".back_idle"}, 64'(o_ready), 64'd1);
    chk({tag, ".valid_drop"}, 64'(o_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset_n     = 1'b0;
    i_valid       = 1'b0;
    i_rd          = '0;
    i_rd_wen      = 1'b0;
    i_result      = '0;
    i_is_load     = 1'b0;
    i_load_funct3 = '0;
    i_rvalid      = 1'b0;
    i_rdata       = '0;
`ifdef WB_COMMIT_TRACE_EN
    i_pc          = '0;
`endif
    tick();
    tick();
    chk("rst.ready", 64'(o_ready), 64'd1);
    chk("rst.valid", 64'(o_valid), 64'd0);
    chk("rst.busy", 64'(o_busy), 64'd0);
    chk("rst.busy_rd", 64'(o_busy_rd), 64'd0);
    chk("rst.rready", 64'(o_rready), 64'd0);
    chk("rst.wen", 64'(o_wen), 64'd0);
    chk("rst.wdata", 64'(o_wdata), 64'd0);
    i_reset_n = 1'b1;
    tick();
    chk("idle.ready", 64'(o_ready), 64'd1);
    chk("idle.valid", 64'(o_valid), 64'd0);

    // Non-load rd=5
    drive_op(5'd5, 1'b1, 32'h1234_5678, 1'b0, 3'b000);
    tick();
    clear_op();
    chk("alu.valid", 64'(o_valid), 64'd1);
    chk("alu.wen", 64'(o_wen), 64'd1);
    chk("alu.waddr", 64'(o_waddr), 64'd5);
    chk("alu.wdata", 64'(o_wdata), 64'h1234_5678);
    chk("alu.ready_low", 64'(o_ready), 64'd0);
    chk("alu.busy", 64'(o_busy), 64'd1);
    chk("alu.busy_rd", 64'(o_busy_rd), 64'd5);
    tick();
    chk("alu.ready_back", 64'(o_ready), 64'd1);
    chk("alu.valid_drop", 64'(o_valid), 64'd0);
    chk("alu.wdata_zero", 64'(o_wdata), 64'd0);
    chk("alu.busy_drop", 64'(o_busy), 64'd0);

    // Back-to-back with i_valid held: second op (rd=0) waits for IDLE
    drive_op(5'd7, 1'b1, 32'hAAAA_0001, 1'b0, 3'b000);
    tick();
    drive_op(5'd0, 1'b1, 32'hBBBB_0002, 1'b0, 3'b000);
    chk("b2b.first_waddr", 64'(o_waddr), 64'd7);
    chk("b2b.first_wdata", 64'(o_wdata), 64'hAAAA_0001);
    tick();
    chk("b2b.gap_valid", 64'(o_valid), 64'd0);
    chk("b2b.gap_ready", 64'(o_ready), 64'd1);
    tick();
    clear_op();
    chk("rd0.valid", 64'(o_valid), 64'd1);
    chk("rd0.wen", 64'(o_wen), 64'd0);
    chk("rd0.wdata", 64'(o_wdata), 64'hBBBB_0002);
    chk("rd0.busy_rd", 64'(o_busy_rd), 64'd0);
    tick();

    // No-write instruction: busy_rd stays 0, commit still pulses
    drive_op(5'd9, 1'b0, 32'h0000_0042, 1'b0, 3'b000);
    tick();
    clear_op();
    chk("nowen.valid", 64'(o_valid), 64'd1);
    chk("nowen.wen", 64'(o_wen), 64'd0);
    chk("nowen.waddr", 64'(o_waddr), 64'd9);
    chk("nowen.busy_rd", 64'(o_busy_rd), 64'd0);
    tick();

    // Stray LSU response in IDLE is ignored
    i_rvalid = 1'b1;
    i_rdata  = 32'h5555_5555;
    tick();
    i_rvalid = 1'b0;
    chk("stray.valid", 64'(o_valid), 64'd0);
    chk("stray.busy", 64'(o_busy), 64'd0);

    do_load("lb3",  5'd10, 3'b000, 32'h1000_0003, 32'h80FF_0000, 3, 32'hFFFF_FF80);
    do_load("lhu2", 5'd11, 3'b101, 32'h1000_0002, 32'h8001_1234, 0, 32'h0000_8001);
    do_load("lw0",  5'd12, 3'b010, 32'h1000_0000, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
    do_load("lh1",  5'd13, 3'b001, 32'h1000_0001, 32'h0000_8765, 0, 32'hFFFF_8765);
    do_load("lbu2", 5'd14, 3'b100, 32'h1000_0002, 32'h00AB_0000, 0, 32'h0000_00AB);
    do_load("lb0",  5'd15, 3'b000, 32'h1000_0000, 32'hFFFF_FF7F, 0, 32'h0000_007F);
    do_load("f3_6", 5'd16, 3'b110, 32'h1000_0001, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);

    // Reset during LOAD_WAIT drops the pending write
    drive_op(5'd20, 1'b1, 32'h2000_0000, 1'b1, 3'b010);
    tick();
    clear_op();
    chk("abort.rready", 64'(o_rready), 64'd1);
    i_reset_n = 1'b0;
    #1;
    chk("abort.async_busy", 64'(o_busy), 64'd0);
    chk("abort.async_ready", 64'(o_ready), 64'd1);
    tick();
    i_reset_n = 1'b1;
    i_rvalid  = 1'b1;
    i_rdata   = 32'h1111_2222;
    tick();
    i_rvalid = 1'b0;
    chk("abort.no_valid", 64'(o_valid), 64'd0);
    chk("abort.idle", 64'(o_ready), 64'd1);
    chk("abort.busy_rd", 64'(o_busy_rd), 64'd0);
    tick();
    chk("abort.still_no_valid", 64'(o_valid), 64'd0);

`ifdef WB_COMMIT_TRACE_EN
    for (int k = 0; k < 3; k++) begin
      i_pc = 32'h8000_0004 + 32'(4 * k);
      drive_op(5'd3, 1'b1, 32'(k), 1'b0, 3'b000);
      tick();
      clear_op();
      chk("trace.valid", 64'(o_valid), 64'd1);
      chk("trace.pc", 64'(o_commit_pc), 64'(32'h8000_0004 + 32'(4 * k)));
      tick();
      chk("trace.pc_zero", 64'(o_commit_pc), 64'd0);
    end
    chk("trace.retired", o_retired, 64'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
